zvc_issue_ctrl: RTL

Issue controller for the 128-lane zero-value compressor. Pulls lowered-IFM lines from upstream with a valid/ready handshake, times each issued line through the compressor's fixed two-stage pipeline (which cannot stall), and emits a write strobe for an external compressed-line FIFO. A credit counter bounds issues so that FIFO can never overflow. Line-index/last tags travel in an internal FIFO kept in lockstep with the data FIFO, and the block signals job completion once every line has been drained downstream.

---
 rtl/zvc_issue_ctrl_pkg.sv | 14 +
 rtl/zvc_issue_ctrl_tag_fifo.sv | 53 +++++
 rtl/zvc_issue_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/zvc_issue_ctrl_pkg.sv
// Shared definitions for the zero-value-compressor issue controller:
// FSM state encodings and the fixed compressor pipeline latency.
package zvc_issue_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   localparam int ZVC_PIPE_LAT = 2;
   localparam int ZVC_LANES    = 128;

endpackage

// File: rtl/zvc_issue_ctrl_tag_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers; used for the line tags
// and, at full line width, as the external compressed-data FIFO.
module zvc_tag_fifo #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             wr_fire, rd_fire;

   assign empty   = wr_ptr_q == rd_ptr_q;
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count   = wr_ptr_q - rd_ptr_q;
   assign wr_fire = wr_en && !full;
   assign rd_fire = rd_en && !empty;
   // Head is forced to zero when empty so the storage itself needs no reset.
   assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_fire};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_fire};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
   end

   a_no_overflow:  assert property (@(posedge clk) disable iff (!reset_n) !(wr_en && full));
   a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n) !(rd_en && empty));

endmodule

// File: rtl/zvc_issue_ctrl.sv
// Issue controller for the 128-lane zero-value compressor: credit-bounded
// line issue, tag delay line matching the compressor latency, FWFT tag FIFO.
module zvc_issue_ctrl
   import zvc_issue_ctrl_pkg::*;
#(
   parameter int LINE_CNT_WIDTH = 16,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic [LINE_CNT_WIDTH-1:0] num_lines,
   output logic                      busy,
   output logic                      done,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic                      issue,
   output logic                      comp_wr,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      rd_pop,
   output logic [LINE_CNT_WIDTH-1:0] out_idx,
   output logic                      out_last
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = LINE_CNT_WIDTH + 1;
   localparam logic [CW-1:0]             CREDIT_MAX = CW'(FIFO_DEPTH);
   localparam logic [AW:0]               ONE_ENTRY  = 1;
   localparam logic [LINE_CNT_WIDTH-1:0] ONE_LINE   = 1;

   state_e                          state_q, state_d;
   logic [LINE_CNT_WIDTH-1:0]       num_lines_q, num_lines_d;
   logic [LINE_CNT_WIDTH-1:0]       issue_idx_q, issue_idx_d;
   logic [CW-1:0]                   credits_q, credits_d;
   logic [ZVC_PIPE_LAT:1]           vld_pipe_q, vld_pipe_d;
   logic [ZVC_PIPE_LAT:1][TW-1:0]   tag_pipe_q, tag_pipe_d;
   logic                            done_q, done_d;
   logic                            last_issue, drain_clear;
   logic                            fifo_empty, fifo_full;
   logic [AW:0]                     fifo_cnt;
   logic [TW-1:0]                   head_tag;

   assign in_ready   = (state_q == ST_RUN) && (credits_q != '0);
   assign issue      = in_valid && in_ready;
   assign comp_wr    = vld_pipe_q[ZVC_PIPE_LAT];
   assign out_valid  = !fifo_empty;
   assign rd_pop     = out_valid && out_ready;
   assign {out_idx, out_last} = head_tag;
   assign busy       = state_q != ST_IDLE;
   assign done       = done_q;
   assign last_issue = issue_idx_q == (num_lines_q - ONE_LINE);

   // Tag/valid delay line tracks each line through the non-stallable compressor.
   always_comb begin
      vld_pipe_d    = vld_pipe_q;
      tag_pipe_d    = tag_pipe_q;
      vld_pipe_d[1] = issue;
      tag_pipe_d[1] = {issue_idx_q, last_issue};
      for (int i = 2; i <= ZVC_PIPE_LAT; i++) begin
         vld_pipe_d[i] = vld_pipe_q[i-1];
         tag_pipe_d[i] = tag_pipe_q[i-1];
      end
   end

   always_comb begin
      credits_d = credits_q;
      if (issue && !rd_pop)      credits_d = credits_q - CW'(1);
      else if (rd_pop && !issue) credits_d = credits_q + CW'(1);
   end

   // Evaluated on next-cycle values so done lands the cycle after the final pop.
   assign drain_clear = (vld_pipe_q == '0) && (credits_d == CREDIT_MAX) &&
                        (fifo_empty || (rd_pop && fifo_cnt == ONE_ENTRY));

   always_comb begin
      state_d     = state_q;
      num_lines_d = num_lines_q;
      issue_idx_d = issue_idx_q;
      done_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               num_lines_d = num_lines;
               issue_idx_d = '0;
               // Nothing is in flight in IDLE, so an empty job drains instantly.
               if (num_lines == '0) done_d  = 1'b1;
               else                 state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (issue) begin
               issue_idx_d = issue_idx_q + ONE_LINE;
               if (last_issue) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (drain_clear) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         num_lines_q <= '0;
         issue_idx_q <= '0;
         credits_q   <= CREDIT_MAX;
         vld_pipe_q  <= '0;
         tag_pipe_q  <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         num_lines_q <= num_lines_d;
         issue_idx_q <= issue_idx_d;
         credits_q   <= credits_d;
         vld_pipe_q  <= vld_pipe_d;
         tag_pipe_q  <= tag_pipe_d;
         done_q      <= done_d;
      end
   end

   zvc_tag_fifo #(
      .WIDTH (TW),
      .DEPTH (FIFO_DEPTH)
   ) u_tag_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (comp_wr),
      .wr_data (tag_pipe_q[ZVC_PIPE_LAT]),
      .rd_en   (rd_pop),
      .rd_data (head_tag),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .count   (fifo_cnt)
   );

   a_credit_max: assert property (@(posedge clk) disable iff (!reset_n)
                                  !(rd_pop && !issue && credits_q == CREDIT_MAX));
   a_credit_min: assert property (@(posedge clk) disable iff (!reset_n)
                                  !(issue && !rd_pop && credits_q == '0));
   a_tag_room:   assert property (@(posedge clk) disable iff (!reset_n)
                                  !(comp_wr && fifo_full && !rd_pop));

endmodule
